pipeline_stall_ctrl: RTL and testbench

Consumes the hazard unit's `load_use_haz` and `control_haz` flags and the instruction and data memory busy signals. Drives the PC and pipeline-register write enables and flushes for the five-stage OTTER pipeline (IF, DE, EX, MEM, WB). A redirect that arrives while fetch is stalled is held in an internal register and replayed once fetch completes. The block also keeps stall and flush performance counters.

---
 rtl/pipeline_stall_ctrl_if.sv | 40 ++++
 rtl/pipeline_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/busy inputs and enable/flush/status outputs of the OTTER stall controller.
interface pipeline_stall_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             load_use_haz;
  logic             control_haz;
  logic [XLEN-1:0]  pc_target;
  logic             imem_busy;
  logic             dmem_busy;

  logic             pc_we;
  logic             pc_use_pend;
  logic [XLEN-1:0]  pend_addr;
  logic             pend_valid;
  logic             if_de_we;
  logic             de_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_de_flush;
  logic             de_ex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Pipeline/hazard side: drives hazards and busy flags, consumes enables.
  modport master (
    output load_use_haz, control_haz, pc_target, imem_busy, dmem_busy,
    input  pc_we, pc_use_pend, pend_addr, pend_valid,
           if_de_we, de_ex_we, ex_mem_we, mem_wb_we,
           if_de_flush, de_ex_flush, state, stall_count, flush_count
  );

  modport slave (
    input  load_use_haz, control_haz, pc_target, imem_busy, dmem_busy,
    output pc_we, pc_use_pend, pend_addr, pend_valid,
           if_de_we, de_ex_we, ex_mem_we, mem_wb_we,
           if_de_flush, de_ex_flush, state, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the five-stage OTTER pipeline, with a redirect
// holding register for branches resolved while fetch is stalled.
module pipeline_stall_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  pipeline_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DSTALL = 2'b01,
    ISTALL = 2'b10,
    REDIR  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]  pend_addr_q;
  logic             pend_capture;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic pc_we, pc_use_pend;
  logic if_de_we, de_ex_we, ex_mem_we, mem_wb_we;
  logic if_de_flush, de_ex_flush;
  logic flush_event;

  // Priority: reset, data freeze, fetch stall, pending replay, redirect, load-use.
  always_comb begin
    pc_we        = 1'b1;
    if_de_we     = 1'b1;
    de_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_de_flush  = 1'b0;
    de_ex_flush  = 1'b0;
    pc_use_pend  = 1'b0;
    pend_capture = 1'b0;
    pend_valid_d = pend_valid_q;
    flush_event  = 1'b0;

    if (RST) begin
      pc_we        = 1'b0;
      if_de_we     = 1'b0;
      de_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      if_de_flush  = 1'b1;
      de_ex_flush  = 1'b1;
      pend_valid_d = 1'b0;
    end else if (bus.dmem_busy) begin
      pc_we     = 1'b0;
      if_de_we  = 1'b0;
      de_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (bus.imem_busy) begin
      pc_we       = 1'b0;
      if_de_we    = 1'b0;
      de_ex_flush = 1'b1;
      if (bus.control_haz && !pend_valid_q) begin
        pend_capture = 1'b1;
        pend_valid_d = 1'b1;
        if_de_flush  = 1'b1;
      end
    end else if (pend_valid_q) begin
      pc_use_pend  = 1'b1;
      if_de_flush  = 1'b1;
      de_ex_flush  = 1'b1;
      pend_valid_d = 1'b0;
      flush_event  = 1'b1;
    end else if (bus.control_haz) begin
      if_de_flush = 1'b1;
      de_ex_flush = 1'b1;
      flush_event = 1'b1;
    end else if (bus.load_use_haz) begin
      pc_we       = 1'b0;
      if_de_we    = 1'b0;
      de_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = RUN;
    if (RST)                              state_d = RUN;
    else if (bus.dmem_busy)               state_d = DSTALL;
    else if (bus.imem_busy && pend_valid_d) state_d = REDIR;
    else if (bus.imem_busy)               state_d = ISTALL;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      if (pend_capture) pend_addr_q <= bus.pc_target;
      if (!pc_we)       stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_event)  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.pc_use_pend = pc_use_pend;
  assign bus.pend_addr   = pend_addr_q;
  assign bus.pend_valid  = pend_valid_q;
  assign bus.if_de_we    = if_de_we;
  assign bus.de_ex_we    = de_ex_we;
  assign bus.ex_mem_we   = ex_mem_we;
  assign bus.mem_wb_we   = mem_wb_we;
  assign bus.if_de_flush = if_de_flush;
  assign bus.de_ex_flush = de_ex_flush;
  assign bus.state       = state_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized and directed bench for pipeline_stall_ctrl against a table-driven model.
module tb_pipeline_stall_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_stall_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  pipeline_stall_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the block must remember between cycles.
  logic             m_known = 1'b0;
  logic             m_pv, m_pv_n;
  logic [XLEN-1:0]  m_pa, m_pa_n;
  logic [1:0]       m_st, m_st_n;
  logic [CNT_W-1:0] m_sc, m_sc_n, m_fc, m_fc_n;

  // Situations in priority order; each maps to a fixed row of enables.
  localparam int M_RESET = 0, M_FREEZE = 1, M_FETCH = 2, M_REPLAY = 3,
                 M_REDIRECT = 4, M_BUBBLE = 5, M_RUN = 6;

  function automatic int situation(logic rst, logic db, logic ib, logic pv, logic ch, logic lu);
    if (rst) return M_RESET;
    if (db)  return M_FREEZE;
    if (ib)  return M_FETCH;
    if (pv)  return M_REPLAY;
    if (ch)  return M_REDIRECT;
    if (lu)  return M_BUBBLE;
    return M_RUN;
  endfunction

  // {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we, if_de_flush, de_ex_flush, pc_use_pend}
  function automatic logic [7:0] row(int sit, logic capture);
    case (sit)
      M_RESET:    return 8'b00000110;
      M_FREEZE:   return 8'b00000000;
      M_FETCH:    return capture ? 8'b00111110 : 8'b00111010;
      M_REPLAY:   return 8'b11111111;
      M_REDIRECT: return 8'b11111110;
      M_BUBBLE:   return 8'b00111010;
      default:    return 8'b11111000;
    endcase
  endfunction

  function automatic logic [7:0] dut_row();
    return {bus.pc_we, bus.if_de_we, bus.de_ex_we, bus.ex_mem_we, bus.mem_wb_we,
            bus.if_de_flush, bus.de_ex_flush, bus.pc_use_pend};
  endfunction

  // Compare process: every mid-cycle, check all outputs and plan the next model state.
  always @(negedge CLK) begin
    int sit;
    logic cap;
    logic [7:0] exp_row;
    sit = situation(RST, bus.dmem_busy, bus.imem_busy, m_pv, bus.control_haz, bus.load_use_haz);
    cap = (sit == M_FETCH) && bus.control_haz && !m_pv;
    exp_row = row(sit, cap);
    if (m_known) begin
      chk("enables", dut_row(), exp_row);
      chk("pend_valid", bus.pend_valid, m_pv);
      chk("pend_addr", bus.pend_addr, m_pa);
      chk("state", bus.state, m_st);
      chk("stall_count", bus.stall_count, m_sc);
      chk("flush_count", bus.flush_count, m_fc);
    end else if (RST) begin
      chk("enables_rst", dut_row(), exp_row);
    end
    if (sit == M_RESET) begin
      m_pv_n = 1'b0; m_pa_n = '0; m_st_n = 2'b00; m_sc_n = '0; m_fc_n = '0;
    end else begin
      m_pv_n = cap ? 1'b1 : (sit == M_REPLAY) ? 1'b0 : m_pv;
      m_pa_n = cap ? bus.pc_target : m_pa;
      m_sc_n = m_sc + ((exp_row[7] == 1'b0) ? 1 : 0);
      m_fc_n = m_fc + ((sit == M_REPLAY || sit == M_REDIRECT) ? 1 : 0);
      if (bus.dmem_busy)      m_st_n = 2'b01;
      else if (bus.imem_busy) m_st_n = m_pv_n ? 2'b11 : 2'b10;
      else                    m_st_n = 2'b00;
    end
  end

  always @(posedge CLK) begin
    if (RST) m_known <= 1'b1;
    m_pv <= m_pv_n; m_pa <= m_pa_n; m_st <= m_st_n; m_sc <= m_sc_n; m_fc <= m_fc_n;
  end

  task automatic step(input logic rst, input logic lu, input logic ch, input logic [XLEN-1:0] tgt,
                      input logic ib, input logic db);
    @(posedge CLK);
    #1;
    RST = rst;
    bus.load_use_haz = lu;
    bus.control_haz  = ch;
    bus.pc_target    = tgt;
    bus.imem_busy    = ib;
    bus.dmem_busy    = db;
    n_vec++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    RST = 1'b0;
    bus.load_use_haz = 1'b0; bus.control_haz = 1'b0; bus.pc_target = '0;
    bus.imem_busy = 1'b0; bus.dmem_busy = 1'b0;

    // Reset with every input high.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      #2;
      chk("rst_we", {bus.pc_we, bus.if_de_we, bus.de_ex_we, bus.ex_mem_we, bus.mem_wb_we}, 5'b00000);
      chk("rst_flush", {bus.if_de_flush, bus.de_ex_flush}, 2'b11);
    end
    idle();
    chk("rst_state", bus.state, 2'b00);
    chk("rst_pv", bus.pend_valid, 1'b0);
    chk("rst_cnt", {bus.stall_count, bus.flush_count}, 64'd0);

    // Load-use bubble.
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    #2;
    chk("lu_we", {bus.pc_we, bus.if_de_we, bus.de_ex_flush, bus.ex_mem_we}, 4'b0011);
    idle();
    chk("lu_sc", bus.stall_count, 32'd1);
    chk("lu_fc", bus.flush_count, 32'd0);

    // Control hazard overrides load-use.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    #2;
    chk("ch_out", {bus.pc_we, bus.pc_use_pend, bus.if_de_flush, bus.de_ex_flush}, 4'b1011);
    idle();
    chk("ch_fc", bus.flush_count, 32'd1);
    chk("ch_sc", bus.stall_count, 32'd0);

    // Redirect captured during a fetch stall, replayed when fetch completes.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
    for (int c = 2; c <= 3; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("rd_addr", bus.pend_addr, 32'h200);
      chk("rd_state", bus.state, 2'b11);
    end
    idle();
    chk("rd_state3", bus.state, 2'b11);
    #2;
    chk("rd_replay", {bus.pc_we, bus.pc_use_pend, bus.if_de_flush, bus.de_ex_flush}, 4'b1111);
    idle();
    chk("rd_pv", bus.pend_valid, 1'b0);
    chk("rd_sc", bus.stall_count, 32'd3);
    chk("rd_fc", bus.flush_count, 32'd1);

    // Data stall dominates everything.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 1'b1);
      #2;
      chk("ds_out", dut_row(), 8'b00000000);
    end
    idle();
    chk("ds_state", bus.state, 2'b01);
    chk("ds_pv", bus.pend_valid, 1'b0);
    chk("ds_sc", bus.stall_count, 32'd2);

    // Reset while a redirect is pending discards it.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rr_pv", bus.pend_valid, 1'b0);
      #2;
      chk("rr_use", bus.pc_use_pend, 1'b0);
    end

    // Random traffic with biased busy/hazard rates.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 25), ($urandom_range(99) < 30),
           $urandom, ($urandom_range(99) < 35), ($urandom_range(99) < 15));
    end
    idle();
    @(posedge CLK);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
